// File: rtl/attention_tile_sequencer.sv
// attention_tile_sequencer: control FSM that walks the 4x4 attention array
// through one head (INT, FRAC, VALUE phases), handshaking operand loads with
// the tile buffer, waiting on the array's done, and driving the array's
// active-low PE/row/head resets. Every output is a registered decode of the
// next state so that outputs line up with the state they describe.
module attention_tile_sequencer #(
    parameter int TILE_CYCLES = 10,
    parameter int TW          = 4,
    parameter int RW          = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] cfg_tiles,
    input  logic [RW-1:0] cfg_rows,
    input  logic [7:0]    cfg_enables,
    input  logic          op_valid,
    input  logic          arr_done,
    input  logic          arr_headprune,
    output logic          op_req,
    output logic [RW-1:0] row_idx,
    output logic [TW-1:0] tile_idx,
    output logic [1:0]    phase,
    output logic          resetPE_n,
    output logic          resetRow_n,
    output logic          resetHead_n,
    output logic [7:0]    enables,
    output logic          mul_integer_flag,
    output logic          mul_fractions_flag,
    output logic          mul_value_flag,
    output logic          last_tile_flag,
    output logic          end_of_row_flag,
    output logic          end_of_head_flag,
    output logic          busy,
    output logic          seq_done,
    output logic          head_pruned
);

    localparam int            CW       = (TILE_CYCLES > 1) ? $clog2(TILE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TILE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WAIT_DONE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [TW-1:0] tiles_lat, tiles_nx;
    logic [RW-1:0] rows_lat, rows_nx;
    logic [7:0]    mask_lat, mask_nx;
    logic [RW-1:0] row_nx;
    logic [TW-1:0] tile_nx;
    logic [1:0]    phase_nx;
    logic          prune_lat, prune_nx;
    logic          pruned_nx;
    logic          last_tile, last_row;

    // Registered-output next values
    logic          op_req_nx;
    logic          rpe_nx, rrow_nx, rhead_nx;
    logic [7:0]    en_nx;
    logic          mi_nx, mf_nx, mv_nx;
    logic          lt_nx, eoh_nx;
    logic          busy_nx, done_nx;
    logic          nx_last_tile, nx_last_row, nx_head_finish;

    assign last_tile = (tile_idx == tiles_lat - TW'(1));
    assign last_row  = (row_idx == rows_lat - RW'(1));

    // Next-state, loop counters and latched configuration
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        tiles_nx  = tiles_lat;
        rows_nx   = rows_lat;
        mask_nx   = mask_lat;
        row_nx    = row_idx;
        tile_nx   = tile_idx;
        phase_nx  = phase;
        prune_nx  = prune_lat;
        pruned_nx = head_pruned;
        if (abort) begin
            // Abort beats every transition, including a same-cycle start.
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tiles_nx  = (cfg_tiles == '0) ? TW'(1) : cfg_tiles;
                        rows_nx   = (cfg_rows == '0) ? RW'(1) : cfg_rows;
                        mask_nx   = cfg_enables;
                        row_nx    = '0;
                        tile_nx   = '0;
                        phase_nx  = 2'd0;
                        cnt_nx    = '0;
                        prune_nx  = 1'b0;
                        pruned_nx = 1'b0;
                        state_nx  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (op_valid) begin
                        cnt_nx   = '0;
                        state_nx = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx = '0;
                        if (last_tile) begin
                            state_nx = S_WAIT_DONE;
                        end else begin
                            // PE accumulation carries across tiles of a row.
                            tile_nx  = tile_idx + TW'(1);
                            state_nx = S_LOAD;
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (arr_done) begin
                        prune_nx = arr_headprune;
                        state_nx = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (!last_row) begin
                        row_nx   = row_idx + RW'(1);
                        tile_nx  = '0;
                        state_nx = S_LOAD;
                    end else if (phase == 2'd2) begin
                        state_nx = S_DONE;
                    end else if (phase == 2'd0 && prune_lat) begin
                        // Prune only counts in the INT phase.
                        pruned_nx = 1'b1;
                        state_nx  = S_DONE;
                    end else begin
                        phase_nx = phase + 2'd1;
                        row_nx   = '0;
                        tile_nx  = '0;
                        cnt_nx   = '0;
                        state_nx = S_LOAD;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs match it
    always_comb begin
        nx_last_tile   = (tile_nx == tiles_nx - TW'(1));
        nx_last_row    = (row_nx == rows_nx - RW'(1));
        nx_head_finish = nx_last_row && ((phase_nx == 2'd2) || ((phase_nx == 2'd0) && prune_nx));
        op_req_nx = 1'b0;
        rpe_nx    = 1'b0;
        rrow_nx   = 1'b0;
        rhead_nx  = 1'b0;
        en_nx     = '0;
        mi_nx     = 1'b0;
        mf_nx     = 1'b0;
        mv_nx     = 1'b0;
        lt_nx     = 1'b0;
        eoh_nx    = 1'b0;
        busy_nx   = 1'b0;
        done_nx   = 1'b0;
        if (state_nx == S_LOAD || state_nx == S_COMPUTE ||
            state_nx == S_WAIT_DONE || state_nx == S_CLEAR) begin
            mi_nx = (phase_nx == 2'd0);
            mf_nx = (phase_nx == 2'd1);
            mv_nx = (phase_nx == 2'd2);
        end
        if (state_nx == S_LOAD || state_nx == S_COMPUTE || state_nx == S_WAIT_DONE) begin
            lt_nx    = nx_last_tile;
            eoh_nx   = nx_last_tile && nx_last_row;
            rpe_nx   = 1'b1;
            rrow_nx  = 1'b1;
            rhead_nx = 1'b1;
        end
        case (state_nx)
            S_LOAD: begin
                op_req_nx = 1'b1;
                busy_nx   = 1'b1;
            end
            S_COMPUTE: begin
                en_nx   = mask_nx;
                busy_nx = 1'b1;
            end
            S_WAIT_DONE: begin
                busy_nx = 1'b1;
            end
            S_CLEAR: begin
                rpe_nx   = 1'b0;
                rrow_nx  = !nx_last_row;
                rhead_nx = !nx_head_finish;
                busy_nx  = 1'b1;
            end
            S_DONE: begin
                busy_nx = 1'b1;
                done_nx = 1'b1;
            end
            default: begin
                busy_nx = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Counters, latched config and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt                <= '0;
            tiles_lat          <= '0;
            rows_lat           <= '0;
            mask_lat           <= '0;
            prune_lat          <= 1'b0;
            row_idx            <= '0;
            tile_idx           <= '0;
            phase              <= 2'd0;
            head_pruned        <= 1'b0;
            op_req             <= 1'b0;
            resetPE_n          <= 1'b0;
            resetRow_n         <= 1'b0;
            resetHead_n        <= 1'b0;
            enables            <= '0;
            mul_integer_flag   <= 1'b0;
            mul_fractions_flag <= 1'b0;
            mul_value_flag     <= 1'b0;
            last_tile_flag     <= 1'b0;
            end_of_row_flag    <= 1'b0;
            end_of_head_flag   <= 1'b0;
            busy               <= 1'b0;
            seq_done           <= 1'b0;
        end else begin
            cnt                <= cnt_nx;
            tiles_lat          <= tiles_nx;
            rows_lat           <= rows_nx;
            mask_lat           <= mask_nx;
            prune_lat          <= prune_nx;
            row_idx            <= row_nx;
            tile_idx           <= tile_nx;
            phase              <= phase_nx;
            head_pruned        <= pruned_nx;
            op_req             <= op_req_nx;
            resetPE_n          <= rpe_nx;
            resetRow_n         <= rrow_nx;
            resetHead_n        <= rhead_nx;
            enables            <= en_nx;
            mul_integer_flag   <= mi_nx;
            mul_fractions_flag <= mf_nx;
            mul_value_flag     <= mv_nx;
            last_tile_flag     <= lt_nx;
            end_of_row_flag    <= lt_nx;
            end_of_head_flag   <= eoh_nx;
            busy               <= busy_nx;
            seq_done           <= done_nx;
        end
    end

endmodule

// File: tb/tb_attention_tile_sequencer.sv
// Testbench for attention_tile_sequencer: a nested phase/row/tile loop model
// produces the expected per-cycle outputs for a whole head plus the stimulus
// to apply, and the DUT is compared against it cycle by cycle.
module tb_attention_tile_sequencer;

    localparam int TC = 10;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [3:0] cfg_tiles;
    logic [5:0] cfg_rows;
    logic [7:0] cfg_enables;
    logic       op_valid, arr_done, arr_headprune;
    logic       op_req;
    logic [5:0] row_idx;
    logic [3:0] tile_idx;
    logic [1:0] phase;
    logic       resetPE_n, resetRow_n, resetHead_n;
    logic [7:0] enables;
    logic       mul_integer_flag, mul_fractions_flag, mul_value_flag;
    logic       last_tile_flag, end_of_row_flag, end_of_head_flag;
    logic       busy, seq_done, head_pruned;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       op_req;
        logic [5:0] row;
        logic [3:0] tile;
        logic [1:0] phase;
        logic       rpe, rrow, rhead;
        logic [7:0] en;
        logic       mi, mf, mv, lt, eor, eoh, busy, sdone, hp;
    } obs_t;

    typedef struct packed {
        logic [2:0] kind;
        logic       ov, ad, pr;
    } drv_t;

    localparam int K_IDLE = 0, K_LOAD = 1, K_COMP = 2, K_WAIT = 3, K_CLEAR = 4, K_DONE = 5;

    obs_t exp_q[$];
    drv_t drv_q[$];
    obs_t idle_after;

    attention_tile_sequencer #(.TILE_CYCLES(TC), .TW(4), .RW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_tiles(cfg_tiles), .cfg_rows(cfg_rows), .cfg_enables(cfg_enables),
        .op_valid(op_valid), .arr_done(arr_done), .arr_headprune(arr_headprune),
        .op_req(op_req), .row_idx(row_idx), .tile_idx(tile_idx), .phase(phase),
        .resetPE_n(resetPE_n), .resetRow_n(resetRow_n), .resetHead_n(resetHead_n),
        .enables(enables),
        .mul_integer_flag(mul_integer_flag), .mul_fractions_flag(mul_fractions_flag),
        .mul_value_flag(mul_value_flag),
        .last_tile_flag(last_tile_flag), .end_of_row_flag(end_of_row_flag),
        .end_of_head_flag(end_of_head_flag),
        .busy(busy), .seq_done(seq_done), .head_pruned(head_pruned)
    );

    always #5 clk = ~clk;

    function automatic obs_t get_obs();
        obs_t o;
        o.op_req = op_req;   o.row = row_idx;      o.tile = tile_idx;   o.phase = phase;
        o.rpe = resetPE_n;   o.rrow = resetRow_n;  o.rhead = resetHead_n;
        o.en = enables;      o.mi = mul_integer_flag; o.mf = mul_fractions_flag;
        o.mv = mul_value_flag; o.lt = last_tile_flag; o.eor = end_of_row_flag;
        o.eoh = end_of_head_flag; o.busy = busy;   o.sdone = seq_done;  o.hp = head_pruned;
        return o;
    endfunction

    // Expected observable outputs for one cycle of a given kind
    function automatic obs_t mk(int kind, int ph, int r, int t, int tiles, int rows,
                                logic [7:0] mask, logic rrow, logic rhead, logic hp);
        obs_t o;
        o = '0;
        o.row = 6'(r); o.tile = 4'(t); o.phase = 2'(ph); o.hp = hp;
        if (kind >= K_LOAD && kind <= K_CLEAR) begin
            o.busy = 1'b1;
            o.mi = (ph == 0); o.mf = (ph == 1); o.mv = (ph == 2);
        end
        if (kind >= K_LOAD && kind <= K_WAIT) begin
            o.rpe = 1'b1; o.rrow = 1'b1; o.rhead = 1'b1;
            o.lt  = (t == tiles - 1);
            o.eor = o.lt;
            o.eoh = o.lt && (r == rows - 1);
        end
        if (kind == K_LOAD) o.op_req = 1'b1;
        if (kind == K_COMP) o.en = mask;
        if (kind == K_CLEAR) begin
            o.rpe = 1'b0; o.rrow = rrow; o.rhead = rhead;
        end
        if (kind == K_DONE) begin
            o.busy = 1'b1; o.sdone = 1'b1;
        end
        return o;
    endfunction

    // Build the expected cycle list for one head with the given stimulus plan
    task automatic build_head(input int tiles, input int rows, input logic [7:0] mask,
                              input int ld_lo, input int ld_hi, input int dd_hi, input int pmode);
        bit stop = 0;
        bit hp = 0;
        int ph, r;
        exp_q.delete(); drv_q.delete();
        ph = 0; r = 0;
        for (int p = 0; p < 3 && !stop; p++) begin
            for (int rr = 0; rr < rows && !stop; rr++) begin
                int dd;
                bit pr, last_row, fin;
                ph = p; r = rr;
                for (int t = 0; t < tiles; t++) begin
                    int d = $urandom_range(ld_hi, ld_lo);
                    for (int i = 0; i <= d; i++) begin
                        exp_q.push_back(mk(K_LOAD, p, rr, t, tiles, rows, mask, 1, 1, 0));
                        drv_q.push_back({3'(K_LOAD), (i == d), 1'b0, 1'b0});
                    end
                    for (int c = 0; c < TC; c++) begin
                        exp_q.push_back(mk(K_COMP, p, rr, t, tiles, rows, mask, 1, 1, 0));
                        drv_q.push_back({3'(K_COMP), 3'b000});
                    end
                end
                dd = $urandom_range(dd_hi, 0);
                pr = (pmode == 1) ? 1'b1 : (pmode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
                for (int i = 0; i <= dd; i++) begin
                    logic pbit = (i == dd) ? pr : ((pmode == 0) ? 1'b0 : 1'($urandom_range(1, 0)));
                    exp_q.push_back(mk(K_WAIT, p, rr, tiles - 1, tiles, rows, mask, 1, 1, 0));
                    drv_q.push_back({3'(K_WAIT), 1'b0, (i == dd), pbit});
                end
                last_row = (rr == rows - 1);
                fin = last_row && (p == 2 || (p == 0 && pr));
                exp_q.push_back(mk(K_CLEAR, p, rr, tiles - 1, tiles, rows, mask, !last_row, !fin, 0));
                drv_q.push_back({3'(K_CLEAR), 3'b000});
                if (fin) begin
                    stop = 1;
                    hp = (p == 0);
                end
            end
        end
        exp_q.push_back(mk(K_DONE, ph, r, tiles - 1, tiles, rows, mask, 0, 0, hp));
        drv_q.push_back({3'(K_DONE), 3'b000});
        idle_after = mk(K_IDLE, ph, r, tiles - 1, tiles, rows, mask, 0, 0, hp);
    endtask

    // Start one head from IDLE and compare every cycle against the model
    task automatic run_head(input string tag, input logic [3:0] ct, input logic [5:0] cr,
                            input logic [7:0] mask, input int ld_lo, input int ld_hi,
                            input int dd_hi, input int pmode);
        int tiles = (ct == 0) ? 1 : int'(ct);
        int rows  = (cr == 0) ? 1 : int'(cr);
        obs_t got;
        build_head(tiles, rows, mask, ld_lo, ld_hi, dd_hi, pmode);
        cfg_tiles = ct; cfg_rows = cr; cfg_enables = mask; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < exp_q.size(); k++) begin
            got = get_obs();
            checks++;
            if (got !== exp_q[k]) begin
                errors++;
                $display("FAIL %s cycle %0d kind %0d: got %h expected %h", tag, k + 1,
                         drv_q[k].kind, got, exp_q[k]);
            end
            // Plan-driven inputs; irrelevant inputs (and restarts with new config) are noise
            op_valid      = (drv_q[k].kind == 3'(K_LOAD)) ? drv_q[k].ov : 1'($urandom_range(1, 0));
            arr_done      = (drv_q[k].kind == 3'(K_WAIT)) ? drv_q[k].ad : 1'($urandom_range(1, 0));
            arr_headprune = (drv_q[k].kind == 3'(K_WAIT)) ? drv_q[k].pr : 1'($urandom_range(1, 0));
            start         = 1'($urandom_range(1, 0));
            cfg_tiles     = 4'($urandom);
            cfg_rows      = 6'($urandom);
            cfg_enables   = 8'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0; op_valid = 1'b0; arr_done = 1'b0; arr_headprune = 1'b0;
        got = get_obs();
        checks++;
        if (got !== idle_after) begin
            errors++;
            $display("FAIL %s idle_after: got %h expected %h", tag, got, idle_after);
        end
    endtask

    task automatic test_reset();
        obs_t got;
        reset = 1'b1; start = 1'b0; abort = 1'b0; op_valid = 1'b0; arr_done = 1'b0;
        arr_headprune = 1'b0; cfg_tiles = '0; cfg_rows = '0; cfg_enables = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        got = get_obs();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, obs_t'(0));
        end
    endtask

    task automatic test_basic();
        run_head("basic_1x1", 4'd1, 6'd1, 8'hA5, 0, 0, 0, 0);
    endtask

    task automatic test_prune();
        run_head("prune_1x1", 4'd1, 6'd1, 8'h3C, 0, 0, 0, 1);
    endtask

    task automatic test_multi_tile();
        run_head("tiles3_rows2", 4'd3, 6'd2, 8'hFF, 0, 0, 0, 0);
    endtask

    task automatic test_load_stall();
        run_head("load_stall5", 4'd1, 6'd1, 8'h81, 5, 5, 0, 0);
    endtask

    task automatic test_zero_cfg();
        run_head("zero_cfg", 4'd0, 6'd0, 8'h5A, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int h = 0; h < 6; h++) begin
            run_head($sformatf("random%0d", h), 4'($urandom_range(4, 0)), 6'($urandom_range(3, 0)),
                     8'($urandom), 0, 3, 3, 2);
        end
    endtask

    task automatic test_abort();
        cfg_tiles = 4'd2; cfg_rows = 6'd1; cfg_enables = 8'hF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (enables !== 8'hF0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_precheck: enables %h busy %b expected f0 1", enables, busy);
        end
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; op_valid = 1'b0;
        checks++;
        if ({busy, resetPE_n, resetRow_n, resetHead_n, enables, seq_done, op_req} !== 13'b0) begin
            errors++;
            $display("FAIL abort_idle: busy %b rst %b%b%b en %h done %b req %b expected all 0",
                     busy, resetPE_n, resetRow_n, resetHead_n, enables, seq_done, op_req);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: busy %b seq_done %b expected 0 0", busy, seq_done);
        end
        run_head("after_abort", 4'd2, 6'd2, 8'h0F, 0, 2, 2, 0);
    endtask

    task automatic test_reset_mid_wait();
        obs_t got, ew;
        cfg_tiles = 4'd1; cfg_rows = 6'd1; cfg_enables = 8'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b1; arr_done = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        ew = mk(K_WAIT, 0, 0, 0, 1, 1, 8'h77, 1, 1, 0);
        got = get_obs();
        checks++;
        if (got !== ew) begin
            errors++;
            $display("FAIL wait_hold: got %h expected %h", got, ew);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0;
        got = get_obs();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_mid_wait: got %h expected %h", got, obs_t'(0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prune();
        test_multi_tile();
        test_load_stall();
        test_zero_cfg();
        test_abort();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/attention_tile_sequencer.md
# attention_tile_sequencer

Control FSM that drives the 4x4 attention array (`ArrangeArray`) through one attention head. The head runs as three matrix phases: integer multiply, fraction multiply, then value multiply. Each phase iterates over a configured number of rows and tiles per row. The block handshakes operand loading with the tile buffer and waits for the array's `done`. It also generates the array's active-low PE, row and head resets and skips the remaining phases when the array reports a head prune.

## Interface
- `TILE_CYCLES`, default 10: compute cycles per 4x4 tile (systolic fill plus drain).
- `TW`, default 4: width of the tile-per-row count.
- `RW`, default 6: width of the row count.
- `clk`  in  1: clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  in  1: begin a head; sampled only in IDLE.
- `abort`  in  1: synchronous cancel; return to IDLE.
- `cfg_tiles`  in  TW: tiles per row; 0 is treated as 1.
- `cfg_rows`  in  RW: rows per phase; 0 is treated as 1.
- `cfg_enables`  in  8: array column/lane enable mask.
- `op_valid`  in  1: tile buffer has presented operands for the current tile.
- `arr_done`  in  1: array `done`.
- `arr_headprune`  in  1: array `headprune`.
- `op_req`  out  1: request operands for tile (`row_idx`, `tile_idx`, `phase`).
- `row_idx`  out  RW: current row.
- `tile_idx`  out  TW: current tile.
- `phase`  out  2: 0=INT, 1=FRAC, 2=VALUE.
- `resetPE_n`, `resetRow_n`, `resetHead_n`  out  1 each: array resets, active-low.
- `enables`  out  8: to the array.
- `mul_integer_flag`, `mul_fractions_flag`, `mul_value_flag`  out  1 each: one-hot phase select.
- `last_tile_flag`, `end_of_row_flag`, `end_of_head_flag`  out  1 each: array tile flags.
- `busy`  out  1: high outside IDLE.
- `seq_done`  out  1: one-cycle pulse when the head completes.
- `head_pruned`  out  1: result of the last head; held until the next `start`.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All three array resets = 0 (asserted).
  - `enables` = 0.
  - All flags = 0.
  - `op_req`, `busy`, `seq_done`, `head_pruned` = 0.
  - `row_idx`, `tile_idx`, `phase` = 0.
- States: IDLE, LOAD, COMPUTE, WAIT_DONE, CLEAR, DONE.
- IDLE:
  - Array resets are held at 0 and `enables` = 0.
  - On `start`: latch the config (0 is mapped to 1), clear the counters and `head_pruned`, then go to LOAD.
- LOAD:
  - `op_req` = 1 and all resets = 1.
  - On `op_valid` = 1, go to COMPUTE and clear the cycle counter.
  - `op_req` remains asserted until `op_valid` is seen.
- COMPUTE:
  - `enables` = latched mask.
  - The counter runs 0 to TILE_CYCLES-1.
  - At the terminal count: if this is not the last tile, increment `tile_idx` and go to LOAD (the PE accumulation is kept). If it is the last tile, go to WAIT_DONE.
- WAIT_DONE:
  - `enables` = 0.
  - Stays here until `arr_done` = 1. There is no timeout; `abort` is the only exit.
  - `arr_headprune` is sampled on the same cycle as `arr_done`.
- CLEAR (one cycle):
  - `resetPE_n` = 0.
  - `resetRow_n` = 0 if this is the last row of the phase.
  - `resetHead_n` = 0 if the head is finishing.
  - Next state:
    - Not last row: increment `row_idx`, set `tile_idx` = 0, go to LOAD.
    - Last row and phase < 2 with no prune: increment the phase, clear the counters, go to LOAD.
    - Last row and phase 2: go to DONE.
    - Last row and phase 0 with the sampled prune = 1: set `head_pruned` = 1, assert `resetHead_n` = 0, go to DONE.
- DONE: `seq_done` = 1 for one cycle, then go to IDLE. The array resets return to 0.
- Phase flags are one-hot by `phase` during LOAD, COMPUTE, WAIT_DONE and CLEAR, and are 0 otherwise.
- Tile flags are levels, valid during LOAD through WAIT_DONE:
  - `last_tile_flag` = `end_of_row_flag` = (`tile_idx` == tiles-1).
  - `end_of_head_flag` = last tile and (`row_idx` == rows-1).
- Prune is honoured only in the INT phase; in FRAC and VALUE it is ignored.
- `start` while `busy` is ignored.
- `abort` has priority over every transition, including `start` in the same cycle. It forces IDLE on the next edge with no `seq_done`; the array resets go to 0 and `op_req` goes to 0.
- `reset` has priority over `abort`.

## Timing
- `start` sampled at edge 0 → LOAD at cycle 1, `op_req` = 1 at cycle 1.
- `op_valid` high during LOAD → COMPUTE on the next cycle; `op_req` = 0 on that cycle.
- Minimum cycles per tile = 1 + TILE_CYCLES; each row adds 1 WAIT_DONE cycle and 1 CLEAR cycle.
- With `op_valid`, `arr_done` = 1 constantly, one phase takes rows·(tiles·(1+TILE_CYCLES)+2) cycles.
- `seq_done` appears in the cycle after the final CLEAR.

## Test plan
- TILE_CYCLES=10, tiles=1, rows=1, `op_valid` = `arr_done` = 1, no prune, `start` at cycle 0 → `seq_done` at cycle 40 only. Phase flags INT cycles 1–13, FRAC 14–26, VALUE 27–39. `head_pruned` = 0.
- Same setup with `arr_headprune` = 1 in the INT WAIT_DONE cycle (cycle 12) → CLEAR at cycle 13 with all three resets = 0. `seq_done` at cycle 14, `head_pruned` = 1. FRAC is never asserted.
- tiles=3, rows=2 → `tile_idx` 0,1,2 per row. `resetPE_n` is low only in the CLEARs, never between tiles. `end_of_head_flag` is high only on row 1, tile 2. `resetRow_n` is low only in the last CLEAR of each phase.
- `op_valid` held low for 5 cycles in LOAD → `op_req` stays 1 for 6 cycles and the COMPUTE start shifts by 5. Same `start` issued while `busy` → ignored, config unchanged.
- `cfg_tiles` = 0, `cfg_rows` = 0 → behaves exactly as tiles=1, rows=1.
- `abort` at COMPUTE count 4, with `start` in the same cycle → next cycle IDLE, `busy` = 0, resets = 0, `enables` = 0, no `seq_done`. A subsequent `start` runs normally. `reset` mid-WAIT_DONE → all outputs return to their reset values on the next edge.
